// File: rtl/pcm_pkg.sv
// pcm_pkg: shared types and constants for the PCM read arbiter.
// Holds the FSM state enumeration, the read-array command word and the
// default phase lengths used as parameter defaults by pcm_rd_arbiter.
package pcm_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_GAP,
      ST_READ,
      ST_DONE
   } pcm_state_e;

   localparam logic [15:0] CMD_READ_ARRAY = 16'h00FF;

   localparam int DEF_WE_CYC  = 7;
   localparam int DEF_GAP_CYC = 1;
   localparam int DEF_RD_CYC  = 13;

endpackage

// File: rtl/pcm_rr_arb.sv
// pcm_rr_arb: two-way round-robin grant for the PCM read arbiter.
// The grant is combinational from req and the pointer; the pointer moves
// only when load is strobed, so a tie goes to the port not granted last.
// After reset the pointer favours port 0.
module pcm_rr_arb (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       load,
   output logic [1:0] grant
);

   // 1 when port 1 received the most recent grant
   logic last_port;

   // pick a single winner; on a tie, the port that did not win last time
   always_comb begin
      grant = 2'b00;
      if (req[0] && req[1]) begin
         grant = last_port ? 2'b01 : 2'b10;
      end else begin
         grant = req;
      end
   end

   // remember the winner whenever the grant is actually taken
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_port <= 1'b1;
      end else if (load && (grant != 2'b00)) begin
         last_port <= grant[1];
      end
   end

endmodule

// File: rtl/pcm_rd_arbiter.sv
// pcm_rd_arbiter: arbitrates two read requesters onto one parallel PCM.
// Each transaction runs CMD (read-array write), GAP, READ, DONE; all
// PCM strobes, ack pulses and the bus enable are registered outputs.
// Optional feature macro: PCM_RDMODE_CACHE_EN -- once a read-array
// command has been issued, later reads skip CMD and GAP until reset.
module pcm_rd_arbiter
   import pcm_pkg::*;
#(
   parameter int WE_CYC  = DEF_WE_CYC,
   parameter int GAP_CYC = DEF_GAP_CYC,
   parameter int RD_CYC  = DEF_RD_CYC
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req0,
   input  logic         req1,
   input  logic [23:0]  addr0,
   input  logic [23:0]  addr1,
   output logic         ack0,
   output logic         ack1,
   output logic [15:0]  rdata0,
   output logic [15:0]  rdata1,
   output logic         busy,
   output logic         cs,
   output logic         oe,
   output logic         we,
   output logic         memrst,
   output logic [24:1]  addr,
   inout  wire  [15:0]  data
);

   localparam int CNT_MAX_A = (WE_CYC > RD_CYC) ? WE_CYC : RD_CYC;
   localparam int CNT_MAX   = (CNT_MAX_A > GAP_CYC) ? CNT_MAX_A : GAP_CYC;
   localparam int CNT_W     = $clog2(CNT_MAX + 1);

   pcm_state_e       state;
   logic [CNT_W-1:0] cnt;
   logic             sel;
   logic             drive;
   logic             load;
   logic             skip_cmd;
   logic [1:0]       grant;

`ifdef PCM_RDMODE_CACHE_EN
   logic             rd_mode;
   assign skip_cmd = rd_mode;
`else
   assign skip_cmd = 1'b0;
`endif

   assign memrst = 1'b1;
   assign data   = drive ? CMD_READ_ARRAY : 16'hzzzz;
   assign load   = (state == ST_IDLE) && (req0 || req1);

   pcm_rr_arb u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req   ({req1, req0}),
      .load  (load),
      .grant (grant)
   );

   // transaction sequencer: state, phase counter and every registered output
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         sel    <= 1'b0;
         addr   <= '0;
         cs     <= 1'b1;
         oe     <= 1'b1;
         we     <= 1'b1;
         drive  <= 1'b0;
         ack0   <= 1'b0;
         ack1   <= 1'b0;
         busy   <= 1'b0;
         rdata0 <= '0;
         rdata1 <= '0;
`ifdef PCM_RDMODE_CACHE_EN
         rd_mode <= 1'b0;
`endif
      end else begin
         ack0 <= 1'b0;
         ack1 <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (req0 || req1) begin
                  sel  <= grant[1];
                  addr <= grant[0] ? addr0 : addr1;
                  busy <= 1'b1;
                  cs   <= 1'b0;
                  if (skip_cmd) begin
                     state <= ST_READ;
                     oe    <= 1'b0;
                     cnt   <= CNT_W'(RD_CYC - 1);
                  end else begin
                     state <= ST_CMD;
                     we    <= 1'b0;
                     drive <= 1'b1;
                     cnt   <= CNT_W'(WE_CYC - 1);
                  end
               end
            end
            ST_CMD: begin
               if (cnt == '0) begin
                  we    <= 1'b1;
                  drive <= 1'b0;
`ifdef PCM_RDMODE_CACHE_EN
                  rd_mode <= 1'b1;
`endif
                  if (GAP_CYC == 0) begin
                     state <= ST_READ;
                     oe    <= 1'b0;
                     cnt   <= CNT_W'(RD_CYC - 1);
                  end else begin
                     state <= ST_GAP;
                     cs    <= 1'b1;
                     cnt   <= CNT_W'(GAP_CYC - 1);
                  end
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            ST_GAP: begin
               if (cnt == '0) begin
                  state <= ST_READ;
                  cs    <= 1'b0;
                  oe    <= 1'b0;
                  cnt   <= CNT_W'(RD_CYC - 1);
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            ST_READ: begin
               if (cnt == '0) begin
                  state <= ST_DONE;
                  cs    <= 1'b1;
                  oe    <= 1'b1;
                  if (sel) begin
                     rdata1 <= data;
                     ack1   <= 1'b1;
                  end else begin
                     rdata0 <= data;
                     ack0   <= 1'b1;
                  end
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
               cs    <= 1'b1;
               oe    <= 1'b1;
               we    <= 1'b1;
               drive <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pcm_rd_arbiter.sv
// tb_pcm_rd_arbiter: scoreboard bench for pcm_rd_arbiter with a small
// PCM read model on the data bus. Honors PCM_RDMODE_CACHE_EN if defined.
module tb_pcm_rd_arbiter;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         req0, req1;
   logic [23:0]  addr0, addr1;
   logic         ack0, ack1;
   logic [15:0]  rdata0, rdata1;
   logic         busy, cs, oe, we, memrst;
   logic [24:1]  pcm_addr;
   tri   [15:0]  data;

   always #5 clk = ~clk;

   pcm_rd_arbiter dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .req0   (req0),
      .req1   (req1),
      .addr0  (addr0),
      .addr1  (addr1),
      .ack0   (ack0),
      .ack1   (ack1),
      .rdata0 (rdata0),
      .rdata1 (rdata1),
      .busy   (busy),
      .cs     (cs),
      .oe     (oe),
      .we     (we),
      .memrst (memrst),
      .addr   (pcm_addr),
      .data   (data)
   );

   function automatic logic [15:0] mem_f(input logic [23:0] a);
      if (a == 24'h100000) return 16'h00A5;
      return (a[15:0] ^ 16'hC33C) + {8'h00, a[23:16]};
   endfunction

   // PCM model drives the bus while the chip is selected and output-enabled
   assign data = (!cs && !oe) ? mem_f(pcm_addr) : 16'hzzzz;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   typedef struct {
      int          port;
      logic [23:0] a;
      logic [15:0] d;
      int          lat;
      int          we_n;
   } item_t;

   item_t sbq[$];
   bit    cache_flag = 1'b0;

   function automatic void sb_push(input int p, input logic [23:0] a);
      item_t it;
      it.port = p;
      it.a    = a;
      it.d    = mem_f(a);
`ifdef PCM_RDMODE_CACHE_EN
      it.lat  = cache_flag ? 14 : 22;
      it.we_n = cache_flag ? 0 : 7;
      cache_flag = 1'b1;
`else
      it.lat  = 22;
      it.we_n = 7;
`endif
      sbq.push_back(it);
   endfunction

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // monitor: per-transaction strobe counts, bus checks, scoreboard pops
   int grant_cyc = 0;
   int we_lo = 0, oe_lo = 0, bad_cmd = 0, bad_z = 0, both_ack = 0;
   int last_ack_cyc [2] = '{0, 0};
   int ack_grant_cyc [2] = '{0, 0};
   logic busy_q = 1'b0;

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (busy && !busy_q) begin
            grant_cyc = cyc;
            we_lo = 0;
            oe_lo = 0;
            bad_cmd = 0;
         end
         if (!we) begin
            we_lo++;
            if (data !== 16'h00FF) bad_cmd++;
         end
         if (!oe) oe_lo++;
         if (we && oe && (data !== 16'hzzzz)) bad_z++;
         if (ack0 && ack1) both_ack++;
         if (ack0 || ack1) begin
            int p;
            p = ack1 ? 1 : 0;
            last_ack_cyc[p] = cyc;
            ack_grant_cyc[p] = grant_cyc;
            if (sbq.size() == 0) begin
               chk("unexpected_ack", 32'(p), 32'hFFFF_FFFF);
            end else begin
               item_t it;
               it = sbq.pop_front();
               chk("ack_port", 32'(p), 32'(it.port));
               chk("latency", 32'(cyc - grant_cyc + 1), 32'(it.lat));
               chk("rdata", {16'h0, (p == 1) ? rdata1 : rdata0}, {16'h0, it.d});
               chk("pcm_addr", {8'h0, pcm_addr}, {8'h0, it.a});
               chk("we_cycles", 32'(we_lo), 32'(it.we_n));
               chk("oe_cycles", 32'(oe_lo), 32'd13);
               chk("cmd_data", 32'(bad_cmd), 32'd0);
            end
         end
      end
      busy_q = busy;
   end

   task automatic requester(input int p, input logic [23:0] a);
      bit done;
      done = 1'b0;
      @(posedge clk);
      #1;
      if (p == 0) begin req0 = 1'b1; addr0 = a; end
      else        begin req1 = 1'b1; addr1 = a; end
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clk);
         if ((p == 0 && ack0) || (p == 1 && ack1)) done = 1'b1;
      end
      if (!done) chk("req_timeout", 32'(p), 32'hFFFF_FFFF);
      @(posedge clk);
      #1;
      if (p == 0) req0 = 1'b0;
      else        req1 = 1'b0;
   endtask

   task automatic idle_checks(input string tag);
      chk({tag, "_cs"},    {31'h0, cs},   32'd1);
      chk({tag, "_oe"},    {31'h0, oe},   32'd1);
      chk({tag, "_we"},    {31'h0, we},   32'd1);
      chk({tag, "_ack"},   {30'h0, ack1, ack0}, 32'd0);
      chk({tag, "_busy"},  {31'h0, busy}, 32'd0);
      chk({tag, "_data_z"}, {16'h0, data}, {16'h0, 16'hzzzz});
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int tie_gap;
      int n_we;
`ifdef PCM_RDMODE_CACHE_EN
      tie_gap = 15;
`else
      tie_gap = 23;
`endif
      rst_n = 1'b0;
      req0 = 1'b0; req1 = 1'b0;
      addr0 = '0;  addr1 = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      idle_checks("reset");
      chk("reset_addr",   {8'h0, pcm_addr}, 32'd0);
      chk("reset_rdata",  {rdata1, rdata0}, 32'd0);
      chk("memrst",       {31'h0, memrst},  32'd1);
      rst_n = 1'b1;

      // first tie after reset goes to port 0, then port 1
      sb_push(0, 24'h000123);
      sb_push(1, 24'h200456);
      fork
         requester(0, 24'h000123);
         requester(1, 24'h200456);
      join
      chk("tie_ack_gap", 32'(last_ack_cyc[1] - last_ack_cyc[0]), 32'(tie_gap));

      // second tie: port 1 was granted last, so port 0 wins again
      sb_push(0, 24'h0A0A0A);
      sb_push(1, 24'h3F0001);
      fork
         requester(0, 24'h0A0A0A);
         requester(1, 24'h3F0001);
      join
      chk("tie2_order", 32'(last_ack_cyc[1] > last_ack_cyc[0]), 32'd1);

      // single read; address input changes after the grant are ignored
      sb_push(0, 24'h100000);
      fork
         requester(0, 24'h100000);
         begin
            repeat (5) @(posedge clk);
            #1 addr0 = 24'h0ABCDE;
         end
      join
      chk("single_rdata0", {16'h0, rdata0}, 32'h0000_00A5);

      // back-to-back: port 1 asks while port 0 is mid-transaction
      sb_push(0, 24'h001000);
      sb_push(1, 24'h7FFFFF);
      fork
         requester(0, 24'h001000);
         begin
            repeat (15) @(posedge clk);
            requester(1, 24'h7FFFFF);
         end
      join
      chk("b2b_ack_gap_ge2", 32'((last_ack_cyc[1] - last_ack_cyc[0]) >= 2), 32'd1);
`ifndef PCM_RDMODE_CACHE_EN
      chk("b2b_regrant", 32'(ack_grant_cyc[1] - last_ack_cyc[0]), 32'd2);
`endif
      chk("rdata0_hold", {16'h0, rdata0}, {16'h0, mem_f(24'h001000)});

      // reset in the third CMD cycle discards the transaction
      @(posedge clk);
      #1;
      req0 = 1'b1;
      addr0 = 24'h055555;
      n_we = 0;
      for (int i = 0; i < 40 && n_we < 3; i++) begin
         @(negedge clk);
         if (!we) n_we++;
      end
      chk("abort_reached_cmd3", 32'(n_we), 32'd3);
      rst_n = 1'b0;
      req0 = 1'b0;
      @(negedge clk);
      idle_checks("abort");
      rst_n = 1'b1;
      cache_flag = 1'b0;
      repeat (3) @(negedge clk);
      chk("abort_no_ack", {30'h0, ack1, ack0}, 32'd0);

      // re-issued request completes with the full command sequence
      sb_push(0, 24'h055555);
      requester(0, 24'h055555);

      // a few random single reads on either port
      for (int k = 0; k < 4; k++) begin
         int p;
         logic [23:0] a;
         p = int'($urandom_range(1, 0));
         a = 24'($urandom);
         sb_push(p, a);
         requester(p, a);
      end

      for (int i = 0; i < 100 && sbq.size() != 0; i++) @(negedge clk);
      chk("sb_drained", 32'(sbq.size()), 32'd0);
      chk("ack_exclusive", 32'(both_ack), 32'd0);
      chk("bus_released", 32'(bad_z), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
